// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues sequential imem reads and buffers {pc, instr} for decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise fetch_err and halt fetch.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetch_err
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW1-1:0] DEPTH_C = CW1'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t                fifo [FIFO_DEPTH];
  entry_t                head;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] fetch_pc, req_pc;
  logic                  inflight, drop, halted, err_q;
  logic                  pop, push, issue, misalign;
  logic [CW1-1:0]        credit;
  logic [ADDR_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target   = redirect_target;
  assign misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  logic unused_target_lo;
  assign unused_target_lo = ^redirect_target[1:0];
  assign target           = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
  assign misalign         = 1'b0;
`endif

  // Head and handshake; a redirect masks the head so a coincident pop is not a transfer.
  assign head        = fifo[rd_ptr];
  assign instr_valid = (count != '0) && !redirect_valid;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;
  assign pop         = instr_valid && instr_ready;

  // Credit counts buffered plus in-flight words, so a response always has a free slot.
  assign credit    = CW1'(count) + CW1'(inflight) - CW1'(pop);
  assign issue     = !rst && !redirect_valid && !halted && (credit < DEPTH_C);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign push      = inflight && !drop && !redirect_valid && !rst;
  assign fetch_err = err_q;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
      halted   <= 1'b0;
      err_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      err_q    <= misalign;
      if (issue) req_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        halted   <= misalign;
        // Issue is already masked during a redirect, so nothing stale is left to discard.
        drop     <= issue;
      end else begin
        if (issue)    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (inflight) drop     <= 1'b0;
        if (push)     wr_ptr   <= wr_ptr + PW'(1);
        if (pop)      rd_ptr   <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
